// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: the FIFO entry format and word helpers.
// `WORD normally comes from consts.v; it falls back to 32 bits when that file is absent.
`ifndef WORD
`define WORD 32
`endif

package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [`WORD-1:0] pc;
        logic [`WORD-1:0] instr;
    } fetch_entry_t;

    function automatic logic [`WORD-1:0] align_word(input logic [`WORD-1:0] addr);
        return {addr[`WORD-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with push/pop/clear and occupancy count; async active-low reset.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_pkg::fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output T                             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: the consumer never looks at head while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem requests under a credit limit,
// discards stale responses after a redirect. Optional FETCH_BYPASS_EN adds an empty-FIFO resp->instr path.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [`WORD-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [`WORD-1:0]  req_addr,
    input  logic              resp_valid,
    input  logic [`WORD-1:0]  resp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [`WORD-1:0]  instr,
    output logic [`WORD-1:0]  instr_pc,
    input  logic              redirect_valid,
    input  logic [`WORD-1:0]  redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);

    logic [`WORD-1:0] fetch_pc;
    logic [`WORD-1:0] rsp_pc;
    logic [CW-1:0]    inflight;
    logic [CW-1:0]    drop;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      used;
    logic             fifo_empty;
    logic             fifo_full;
    logic             credit_ok;
    logic             req_fire;
    logic             resp_live;
    logic             bypass;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     fifo_head;
    fetch_entry_t     shown;
    fetch_entry_t     hold_q;

    assign used      = {1'b0, fifo_count} + {1'b0, inflight};
    assign credit_ok = (used < (CW+1)'(DEPTH));
    assign req_valid = rst_n && !redirect_valid && credit_ok;
    assign req_addr  = fetch_pc;
    assign req_fire  = req_valid && req_ready;

    assign resp_live  = resp_valid && (drop == '0) && !redirect_valid;
    assign push_entry = '{pc: rsp_pc, instr: resp_data};

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_live && fifo_empty && instr_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_live && !bypass;
    assign pop  = !fifo_empty && instr_ready && !redirect_valid;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // hold_q keeps the last word shown so instr/instr_pc stay stable while empty.
    always_comb begin
        instr_valid = !fifo_empty || bypass;
        shown       = hold_q;
        if (bypass) begin
            shown = push_entry;
        end else if (!fifo_empty) begin
            shown = fifo_head;
        end
        instr    = shown.instr;
        instr_pc = shown.pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            hold_q   <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(resp_valid);
            if (redirect_valid) begin
                fetch_pc <= align_word(redirect_pc);
                rsp_pc   <= align_word(redirect_pc);
                // Every request still outstanding after this cycle belongs to the old stream.
                drop     <= inflight - CW'(resp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + `WORD'(INSTR_BYTES);
                end
                if (resp_valid) begin
                    if (drop != '0) begin
                        drop <= drop - 1'b1;
                    end else begin
                        rsp_pc <= rsp_pc + `WORD'(INSTR_BYTES);
                    end
                end
            end
            if (instr_valid) begin
                hold_q <= shown;
            end
        end
    end

    a_resp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_valid && inflight == '0));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed segment table, hand sequences, randomized traffic vs a queue model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } pend_t;

    typedef struct {
        int          lat;
        bit          rr;
        bit          ir;
        int          n;
        int          exp_acc;
        logic [31:0] exp_next;
    } seg_t;

    pend_t       pend[$];
    logic [31:0] mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] del_log[$];
    logic [31:0] m_fetch;
    logic [31:0] rpc;
    int          cur_epoch;
    int          cyc;
    int          last_due;
    int          lat;
    int          acc_cnt;
    int          checks;
    int          errors;
    bit          rr, ir, rv;
    seg_t        segs[5];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_log(input string name, input logic [31:0] q[$], input int idx,
                             input logic [31:0] exp);
        if (q.size() > idx) begin
            check(name, q[idx], exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: only %0d entries seen, expected entry %0d = %h", name, q.size(), idx, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance the model past the edge.
    task automatic cycle();
        bit          resp_now, live, byp, exp_req, exp_iv;
        logic [31:0] exp_pc;
        pend_t       p;
        int          d;
        @(negedge clk);
        cyc++;
        req_ready      = rr;
        instr_ready    = ir;
        redirect_valid = rv;
        redirect_pc    = rpc;
        resp_now       = (pend.size() > 0) && (pend[0].due <= cyc);
        resp_valid     = resp_now;
        resp_data      = resp_now ? word_of(pend[0].addr) : $urandom;
        #2;
        live    = resp_now && (pend[0].ep == cur_epoch) && !rv;
        exp_req = !rv && (mq.size() + pend.size() < DEPTH);
        byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp     = live && (mq.size() == 0) && ir;
`endif
        exp_iv  = (mq.size() > 0) || byp;
        exp_pc  = (mq.size() > 0) ? mq[0] : (resp_now ? pend[0].addr : 32'h0);

        check("req_valid", req_valid, exp_req);
        if (exp_req && req_valid) check("req_addr", req_addr, m_fetch);
        check("instr_valid", instr_valid, exp_iv);
        if (exp_iv && instr_valid) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, word_of(exp_pc));
        end

        if (instr_valid && ir && !rv) del_log.push_back(instr_pc);

        if (rv) begin
            mq.delete();
            cur_epoch++;
            m_fetch = {rpc[31:2], 2'b00};
            if (resp_now) pend.delete(0);
        end else begin
            if (exp_iv && ir && !byp) mq.delete(0);
            if (resp_now) begin
                p = pend[0];
                pend.delete(0);
                if (p.ep == cur_epoch && !byp) mq.push_back(p.addr);
            end
            if (req_valid && rr) m_fetch += 32'd4;
        end

        if (req_valid && rr) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{addr: req_addr, due: d, ep: cur_epoch});
            acc_cnt++;
            acc_log.push_back(req_addr);
        end
    endtask

    task automatic hard_reset();
        rst_n          = 1'b0;
        req_ready      = 1'b0;
        instr_ready    = 1'b0;
        resp_valid     = 1'b0;
        resp_data      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rr = 1'b0; ir = 1'b0; rv = 1'b0; rpc = '0;
        pend.delete();
        mq.delete();
        m_fetch  = RPC;
        last_due = 0;
        #1;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_req_addr", req_addr, RPC);
    endtask

    initial begin
        int a0;
        checks = 0; errors = 0; cyc = 0; acc_cnt = 0; cur_epoch = 0; lat = 1;

        segs[0] = '{lat: 1, rr: 1'b1, ir: 1'b1, n: 8,  exp_acc: 8, exp_next: 32'h20};
        segs[1] = '{lat: 1, rr: 1'b0, ir: 1'b1, n: 5,  exp_acc: 0, exp_next: 32'h20};
        segs[2] = '{lat: 1, rr: 1'b1, ir: 1'b0, n: 10, exp_acc: 4, exp_next: 32'h30};
        segs[3] = '{lat: 1, rr: 1'b1, ir: 1'b1, n: 10, exp_acc: 9, exp_next: 32'h54};
        segs[4] = '{lat: 3, rr: 1'b0, ir: 1'b1, n: 8,  exp_acc: 0, exp_next: 32'h54};

        #1;
        hard_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            lat = segs[i].lat; rr = segs[i].rr; ir = segs[i].ir; rv = 1'b0;
            a0 = acc_cnt;
            repeat (segs[i].n) cycle();
            @(posedge clk); #1;
            check($sformatf("seg%0d_accepted", i), acc_cnt - a0, segs[i].exp_acc);
            check($sformatf("seg%0d_next_addr", i), req_addr, segs[i].exp_next);
        end

        // Redirect with two requests in flight at latency 3.
        lat = 3; rr = 1'b1; ir = 1'b1; rv = 1'b0;
        a0 = acc_cnt;
        repeat (2) cycle();
        check("t3_in_flight", acc_cnt - a0, 2);
        del_log.delete();
        rv = 1'b1; rpc = 32'h103;
        cycle();
        rv = 1'b0;
        repeat (12) cycle();
        check_log("t3_first_pc", del_log, 0, 32'h100);
        check_log("t3_second_pc", del_log, 1, 32'h104);

        // Redirect while the FIFO is pushing and popping in the same cycle.
        lat = 1; rr = 1'b1; ir = 1'b1;
        repeat (6) cycle();
        rv = 1'b1; rpc = 32'h200;
        cycle();
        rv = 1'b0;
        @(posedge clk); #1;
        check("t4_instr_valid_after_redirect", instr_valid, 1'b0);
        repeat (4) cycle();

        // Fetch PC wrap at the top of the address space; low bits of redirect_pc ignored.
        acc_log.delete();
        rv = 1'b1; rpc = 32'hFFFF_FFFF;
        cycle();
        rv = 1'b0;
        repeat (4) cycle();
        check_log("t5_addr_top", acc_log, 0, 32'hFFFF_FFFC);
        check_log("t5_addr_wrap", acc_log, 1, 32'h0000_0000);

        // Reset with three requests outstanding.
        lat = 5; rr = 1'b0; ir = 1'b1;
        repeat (10) cycle();
        rr = 1'b1; ir = 1'b0;
        a0 = acc_cnt;
        repeat (3) cycle();
        check("t6_in_flight", acc_cnt - a0, 3);
        @(posedge clk); #2;
        hard_reset();
        @(negedge clk);
        rst_n = 1'b1;
        acc_log.delete();
        del_log.delete();
        lat = 1; rr = 1'b1; ir = 1'b1;
        repeat (6) cycle();
        check_log("t6_restart_addr", acc_log, 0, RPC);
        check_log("t6_restart_pc", del_log, 0, RPC);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            lat = $urandom_range(1, 4);
            rr  = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 39) == 0);
            rpc = $urandom;
            cycle();
        end
        rv = 1'b0;
        repeat (2) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
